clarvi_dmem_arbiter: RTL and testbench
======================================

Name: clarvi_dmem_arbiter

Overview:
Two-requester arbiter sharing the single word-addressed data memory port. Requester 0 is the core load/store unit; requester 1 is a secondary master (debug/DMA). Supports locked multi-beat sequences, so a 64-bit two-part access is never interleaved with the other requester. Routes 1-cycle-latency read data back to the requester that issued the read.

Parameters:
DATA_ADDR_WIDTH, 14, word address width of memory and both requesters

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
rq0_address  in  DATA_ADDR_WIDTH  requester 0 word address
rq0_byte_enable  in  4  requester 0 byte lanes
rq0_read_enable  in  1  requester 0 read request
rq0_write_enable  in  1  requester 0 write request
rq0_write_data  in  32  requester 0 store data
rq0_lock  in  1  hold ownership after this beat
rq0_wait  out  1  request not accepted this cycle; hold request
rq0_read_valid  out  1  read_data belongs to requester 0 this cycle
rq1_* (address, byte_enable, read_enable, write_enable, write_data, lock, wait, read_valid)  same as rq0_*, for requester 1
read_data  out  32  memory read data, broadcast to both requesters
mem_address  out  DATA_ADDR_WIDTH  memory word address
mem_byte_enable  out  4  memory byte lanes
mem_read_enable  out  1  memory read strobe
mem_write_enable  out  1  memory write strobe
mem_write_data  out  32  memory store data
mem_read_data  in  32  memory read data, valid 1 cycle after mem_read_enable

Behaviour:
- Request n active when rqn_read_enable | rqn_write_enable. Both enables high at once is illegal; write wins, read suppressed.
- State machine: FREE, OWN0, OWN1. Reset -> FREE.
- FREE: arbitrate combinationally the same cycle. Single request granted. Both requesting -> requester 0 wins (fixed priority, see optional feature). Granted access drives mem_* that cycle (zero added latency). Loser sees wait=1.
- Granted beat with rqn_lock=1 -> next state OWNn. Granted beat with lock=0 -> FREE.
- OWNn: only requester n can be granted. The other requester's wait=1 whenever it requests, even if n is idle. n granted with lock=0 -> FREE; lock=1 -> stay OWNn. n idle -> stay OWNn, with no timeout.
- No request: mem_read_enable = mem_write_enable = 0. mem_address/byte_enable/write_data = 0 (not x).
- wait is combinational: rqn_wait = request_n & ~grant_n. A request is never granted and waited in the same cycle.
- Read return: on a granted read, register owner id and pending = 1. Next cycle, rqn_read_valid = pending & (owner == n). read_data = mem_read_data, passed through unregistered.
- Back-to-back reads from alternating requesters: each read_valid is tagged correctly. pending is reloaded every cycle.
- Write grants do not set pending.
- Reset mid-lock: state returns to FREE.
- Reset with a read outstanding: pending cleared, so no read_valid is produced the cycle after reset.
- Reset values: state FREE, pending 0, owner 0, last_grant 0. All wait/read_valid outputs are 0 during reset; all mem_* strobes are 0 during reset.

Optional Feature:
Macro DMEM_ARB_ROUND_ROBIN_EN.
- Defined: a last_grant register is updated on each granted beat issued from FREE. On a FREE-state collision, the requester not granted last wins.
- Undefined: fixed priority, requester 0 always wins collisions; no last_grant register is built.
- Lock behaviour is identical in both builds.

Test Plan:
- Single read rq0 addr 0x010, memory returns 0xDEADBEEF -> mem_read_enable same cycle, rq0_read_valid=1 with read_data 0xDEADBEEF next cycle, rq1_read_valid=0.
- Simultaneous rq0 write 0x020 and rq1 read 0x030, no lock -> rq0 granted, rq1_wait=1. Next cycle rq1 granted, mem_address=0x030.
- rq0 two-beat locked access (beat 1 lock=1, one idle cycle, beat 2 lock=0) with rq1 requesting throughout -> rq1_wait=1 for all three cycles, granted in the 4th.
- Alternating reads rq0 0x001, rq1 0x002, rq0 0x003 on consecutive cycles -> read_valid tags 0,1,0 on the following cycles. A collision on any of these cycles serialises with wait.
- Reset asserted during OWN1 with a read outstanding -> after reset: no read_valid, state FREE, rq0 request granted immediately.
- DMEM_ARB_ROUND_ROBIN_EN defined, both requesting continuously with no lock -> grants alternate 0,1,0,1. Undefined -> requester 0 granted every cycle.

Source files
------------

// File: rtl/clarvi_dmem_arbiter.sv
// Two-requester arbiter for the shared word-addressed data memory port, with locked
// multi-beat ownership and tagged read return. Define DMEM_ARB_ROUND_ROBIN_EN for round-robin collisions.
module clarvi_dmem_arbiter #(
    parameter int DATA_ADDR_WIDTH = 14
) (
    input  logic                       clock,
    input  logic                       reset,

    input  logic [DATA_ADDR_WIDTH-1:0] rq0_address,
    input  logic [3:0]                 rq0_byte_enable,
    input  logic                       rq0_read_enable,
    input  logic                       rq0_write_enable,
    input  logic [31:0]                rq0_write_data,
    input  logic                       rq0_lock,
    output logic                       rq0_wait,
    output logic                       rq0_read_valid,

    input  logic [DATA_ADDR_WIDTH-1:0] rq1_address,
    input  logic [3:0]                 rq1_byte_enable,
    input  logic                       rq1_read_enable,
    input  logic                       rq1_write_enable,
    input  logic [31:0]                rq1_write_data,
    input  logic                       rq1_lock,
    output logic                       rq1_wait,
    output logic                       rq1_read_valid,

    output logic [31:0]                read_data,
    output logic [DATA_ADDR_WIDTH-1:0] mem_address,
    output logic [3:0]                 mem_byte_enable,
    output logic                       mem_read_enable,
    output logic                       mem_write_enable,
    output logic [31:0]                mem_write_data,
    input  logic [31:0]                mem_read_data
);

    localparam logic [1:0] FREE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0] state_q, state_d;
    logic       pending_q, pending_d;
    logic       owner_q, owner_d;
    logic       req0, req1, rd0, rd1;
    logic       grant0, grant1;
    logic       pick1;

    assign req0 = rq0_read_enable | rq0_write_enable;
    assign req1 = rq1_read_enable | rq1_write_enable;
    // A simultaneous write and read is treated as a write only.
    assign rd0  = rq0_read_enable & ~rq0_write_enable;
    assign rd1  = rq1_read_enable & ~rq1_write_enable;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    assign pick1        = ~last_grant_q;
    assign last_grant_d = (state_q == FREE && (grant0 || grant1)) ? grant1 : last_grant_q;

    always_ff @(posedge clock) begin
        if (reset) last_grant_q <= 1'b0;
        else       last_grant_q <= last_grant_d;
    end
`else
    assign pick1 = 1'b0;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            case (state_q)
                FREE: begin
                    if (req0 && req1) begin
                        grant1 = pick1;
                        grant0 = ~pick1;
                    end else begin
                        grant0 = req0;
                        grant1 = req1;
                    end
                end
                OWN0:    grant0 = req0;
                OWN1:    grant1 = req1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FREE: begin
                if (grant0 && rq0_lock)      state_d = OWN0;
                else if (grant1 && rq1_lock) state_d = OWN1;
            end
            OWN0:    if (grant0 && !rq0_lock) state_d = FREE;
            OWN1:    if (grant1 && !rq1_lock) state_d = FREE;
            default: state_d = FREE;
        endcase
    end

    assign pending_d = (grant0 & rd0) | (grant1 & rd1);
    assign owner_d   = pending_d ? grant1 : owner_q;

    always_comb begin
        mem_address      = '0;
        mem_byte_enable  = '0;
        mem_write_data   = '0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        if (grant1) begin
            mem_address      = rq1_address;
            mem_byte_enable  = rq1_byte_enable;
            mem_write_data   = rq1_write_data;
            mem_read_enable  = rd1;
            mem_write_enable = rq1_write_enable;
        end else if (grant0) begin
            mem_address      = rq0_address;
            mem_byte_enable  = rq0_byte_enable;
            mem_write_data   = rq0_write_data;
            mem_read_enable  = rd0;
            mem_write_enable = rq0_write_enable;
        end
    end

    // Gating with reset keeps all handshakes quiet while reset is held.
    assign rq0_wait       = req0 & ~grant0 & ~reset;
    assign rq1_wait       = req1 & ~grant1 & ~reset;
    assign rq0_read_valid = pending_q & ~owner_q & ~reset;
    assign rq1_read_valid = pending_q &  owner_q & ~reset;
    assign read_data      = mem_read_data;

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q   <= FREE;
            pending_q <= 1'b0;
            owner_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            owner_q   <= owner_d;
        end
    end

endmodule

// File: tb/tb_clarvi_dmem_arbiter.sv
// Directed self-checking bench for clarvi_dmem_arbiter; expected values are hand-computed.
// Honours DMEM_ARB_ROUND_ROBIN_EN in the continuous-collision step.
module tb_clarvi_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [13:0] rq0_address, rq1_address;
    logic [3:0]  rq0_byte_enable, rq1_byte_enable;
    logic        rq0_read_enable, rq1_read_enable;
    logic        rq0_write_enable, rq1_write_enable;
    logic [31:0] rq0_write_data, rq1_write_data;
    logic        rq0_lock, rq1_lock;
    logic        rq0_wait, rq1_wait;
    logic        rq0_read_valid, rq1_read_valid;
    logic [31:0] read_data;
    logic [13:0] mem_address;
    logic [3:0]  mem_byte_enable;
    logic        mem_read_enable, mem_write_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    clarvi_dmem_arbiter #(.DATA_ADDR_WIDTH(14)) dut (
        .clock            (clock),
        .reset            (reset),
        .rq0_address      (rq0_address),
        .rq0_byte_enable  (rq0_byte_enable),
        .rq0_read_enable  (rq0_read_enable),
        .rq0_write_enable (rq0_write_enable),
        .rq0_write_data   (rq0_write_data),
        .rq0_lock         (rq0_lock),
        .rq0_wait         (rq0_wait),
        .rq0_read_valid   (rq0_read_valid),
        .rq1_address      (rq1_address),
        .rq1_byte_enable  (rq1_byte_enable),
        .rq1_read_enable  (rq1_read_enable),
        .rq1_write_enable (rq1_write_enable),
        .rq1_write_data   (rq1_write_data),
        .rq1_lock         (rq1_lock),
        .rq1_wait         (rq1_wait),
        .rq1_read_valid   (rq1_read_valid),
        .read_data        (read_data),
        .mem_address      (mem_address),
        .mem_byte_enable  (mem_byte_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where new stimulus is applied.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Outputs are sampled on the falling edge, well away from the active edge.
    task automatic mid();
        @(negedge clock);
    endtask

    task automatic idle0();
        rq0_read_enable = 1'b0; rq0_write_enable = 1'b0; rq0_lock = 1'b0;
        rq0_address = '0; rq0_byte_enable = '0; rq0_write_data = '0;
    endtask

    task automatic idle1();
        rq1_read_enable = 1'b0; rq1_write_enable = 1'b0; rq1_lock = 1'b0;
        rq1_address = '0; rq1_byte_enable = '0; rq1_write_data = '0;
    endtask

    task automatic rd0(input logic [13:0] a, input logic lk);
        rq0_read_enable = 1'b1; rq0_write_enable = 1'b0; rq0_lock = lk;
        rq0_address = a; rq0_byte_enable = 4'hF; rq0_write_data = '0;
    endtask

    task automatic rd1(input logic [13:0] a, input logic lk);
        rq1_read_enable = 1'b1; rq1_write_enable = 1'b0; rq1_lock = lk;
        rq1_address = a; rq1_byte_enable = 4'hF; rq1_write_data = '0;
    endtask

    initial begin
        logic exp_last;
        logic win;

        reset = 1'b1;
        mem_read_data = '0;
        rd0(14'h3FF, 1'b0);
        rq1_read_enable = 1'b0; rq1_write_enable = 1'b1; rq1_lock = 1'b0;
        rq1_address = 14'h3FE; rq1_byte_enable = 4'hF; rq1_write_data = 32'hFFFF_FFFF;

        // Reset held with both requesters active: everything quiet.
        cyc(); cyc(); mid();
        check("rst_wait0", rq0_wait, 0);
        check("rst_wait1", rq1_wait, 0);
        check("rst_mem_re", mem_read_enable, 0);
        check("rst_mem_we", mem_write_enable, 0);
        check("rst_rv0", rq0_read_valid, 0);

        cyc(); reset = 1'b0; idle0(); idle1(); mid();
        check("idle_addr", mem_address, 0);
        check("idle_be", mem_byte_enable, 0);
        check("idle_wdata", mem_write_data, 0);
        check("idle_re", mem_read_enable, 0);

        // Single read from requester 0.
        cyc(); rd0(14'h010, 1'b0); mid();
        check("t1_re", mem_read_enable, 1);
        check("t1_addr", mem_address, 32'h010);
        check("t1_wait0", rq0_wait, 0);
        cyc(); idle0(); mem_read_data = 32'hDEAD_BEEF; mid();
        check("t1_rv0", rq0_read_valid, 1);
        check("t1_rdata", read_data, 32'hDEAD_BEEF);
        check("t1_rv1", rq1_read_valid, 0);

        // Single write from requester 1; a write leaves nothing pending.
        cyc(); mem_read_data = '0;
        rq1_write_enable = 1'b1; rq1_address = 14'h005; rq1_byte_enable = 4'h3;
        rq1_write_data = 32'h1234_5678; mid();
        check("w1_we", mem_write_enable, 1);
        check("w1_wdata", mem_write_data, 32'h1234_5678);
        check("w1_be", mem_byte_enable, 4'h3);
        cyc(); idle1(); mid();
        check("w1_rv0", rq0_read_valid, 0);
        check("w1_rv1", rq1_read_valid, 0);

        // Collision: rq0 write vs rq1 read; rq0 wins, rq1 follows.
        cyc();
        rq0_write_enable = 1'b1; rq0_address = 14'h020; rq0_byte_enable = 4'hF;
        rq0_write_data = 32'hA5A5_A5A5;
        rd1(14'h030, 1'b0); mid();
        check("t2_we", mem_write_enable, 1);
        check("t2_addr", mem_address, 32'h020);
        check("t2_wait0", rq0_wait, 0);
        check("t2_wait1", rq1_wait, 1);
        check("t2_re", mem_read_enable, 0);
        cyc(); idle0(); mid();
        check("t2b_addr", mem_address, 32'h030);
        check("t2b_wait1", rq1_wait, 0);
        check("t2b_re", mem_read_enable, 1);
        cyc(); idle1(); mem_read_data = 32'hCAFE_F00D; mid();
        check("t2c_rv1", rq1_read_valid, 1);
        check("t2c_rv0", rq0_read_valid, 0);
        check("t2c_rdata", read_data, 32'hCAFE_F00D);

        // Locked two-beat access by rq0 with rq1 writing throughout.
        cyc(); mem_read_data = 32'h0000_1111;
        rd0(14'h040, 1'b1);
        rq1_write_enable = 1'b1; rq1_address = 14'h050; rq1_byte_enable = 4'hF;
        rq1_write_data = 32'h5555_AAAA; mid();
        check("t3a_addr", mem_address, 32'h040);
        check("t3a_wait0", rq0_wait, 0);
        check("t3a_wait1", rq1_wait, 1);
        cyc(); idle0(); mid();
        check("t3b_wait1", rq1_wait, 1);
        check("t3b_we", mem_write_enable, 0);
        check("t3b_rv0", rq0_read_valid, 1);
        cyc(); rd0(14'h041, 1'b0); mid();
        check("t3c_wait1", rq1_wait, 1);
        check("t3c_addr", mem_address, 32'h041);
        cyc(); idle0(); mid();
        check("t3d_wait1", rq1_wait, 0);
        check("t3d_we", mem_write_enable, 1);
        check("t3d_addr", mem_address, 32'h050);
        check("t3d_wdata", mem_write_data, 32'h5555_AAAA);
        cyc(); idle1(); mid();
        check("t3e_rv0", rq0_read_valid, 0);

        // Alternating reads rq0, rq1, rq0 on consecutive cycles.
        cyc(); rd0(14'h001, 1'b0); mid();
        check("t4a_addr", mem_address, 32'h001);
        cyc(); idle0(); rd1(14'h002, 1'b0); mem_read_data = 32'h0000_0A01; mid();
        check("t4b_addr", mem_address, 32'h002);
        check("t4b_rv0", rq0_read_valid, 1);
        check("t4b_rv1", rq1_read_valid, 0);
        cyc(); idle1(); rd0(14'h003, 1'b0); mem_read_data = 32'h0000_0A02; mid();
        check("t4c_addr", mem_address, 32'h003);
        check("t4c_rv0", rq0_read_valid, 0);
        check("t4c_rv1", rq1_read_valid, 1);
        check("t4c_rdata", read_data, 32'h0000_0A02);
        cyc(); idle0(); mem_read_data = 32'h0000_0A03; mid();
        check("t4d_rv0", rq0_read_valid, 1);
        check("t4d_rv1", rq1_read_valid, 0);

        // rq1 takes a lock and has a read outstanding when reset hits.
        cyc(); rd1(14'h060, 1'b1); mid();
        check("t5a_re", mem_read_enable, 1);
        cyc(); rd1(14'h061, 1'b1); mid();
        check("t5b_addr", mem_address, 32'h061);
        cyc(); idle1(); reset = 1'b1; mid();
        check("t5_rst_rv1", rq1_read_valid, 0);
        cyc(); reset = 1'b0; rd0(14'h070, 1'b0); mid();
        check("t5_post_rv1", rq1_read_valid, 0);
        check("t5_post_wait0", rq0_wait, 0);
        check("t5_post_re", mem_read_enable, 1);
        check("t5_post_addr", mem_address, 32'h070);
        cyc(); idle0(); mid();
        check("t5_post_rv0", rq0_read_valid, 1);

        // Continuous unlocked collision; last grant from FREE was rq0.
        exp_last = 1'b0;
        cyc(); rd0(14'h100, 1'b0); rd1(14'h200, 1'b0);
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            win = ~exp_last;
`else
            win = 1'b0;
`endif
            exp_last = win;
            mid();
            check($sformatf("t6_addr%0d", i), mem_address, win ? 32'h200 : 32'h100);
            check($sformatf("t6_wait0_%0d", i), rq0_wait, {31'b0, win});
            check($sformatf("t6_wait1_%0d", i), rq1_wait, {31'b0, ~win});
            cyc();
        end
        idle0(); idle1();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
